// File: rtl/ysyx_24100029_fetch_queue.sv
// Multi-issue fetch queue: compacts a sparse IFU lane group into a circular buffer
// and presents the oldest OUT_W entries to decode.
module ysyx_24100029_fetch_queue #(
  parameter int DEPTH      = 16,
  parameter int IN_W       = 4,
  parameter int OUT_W      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [IN_W-1:0]              in_valid,
  input  logic [IN_W*INST_WIDTH-1:0]   in_inst,
  input  logic [IN_W*ADDR_WIDTH-1:0]   in_pc,
  input  logic [IN_W-1:0]              in_pred,
  output logic                         in_ready,
  output logic [OUT_W-1:0]             out_valid,
  output logic [OUT_W*INST_WIDTH-1:0]  out_inst,
  output logic [OUT_W*ADDR_WIDTH-1:0]  out_pc,
  output logic [OUT_W-1:0]             out_pred,
  input  logic [OUT_W-1:0]             out_ready,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] ROOM = CW'(DEPTH - IN_W);

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
  } entry_t;

  entry_t mem [DEPTH];

  logic [CW-1:0]              head, tail, n_in, n_out;
  logic [IN_W-1:0][PW-1:0]    off, widx;
  logic                       enq, run;

  // Pointers carry a wrap bit, so the difference is the occupancy, 0..DEPTH.
  assign count    = tail - head;
  assign in_ready = count <= ROOM;
  assign enq      = in_ready && (n_in != '0) && !flush;

  // Compaction: each valid lane lands at tail + (number of valid lanes below it).
  always_comb begin
    n_in = '0;
    for (int i = 0; i < IN_W; i++) begin
      off[i] = n_in[PW-1:0];
      n_in   = n_in + CW'(in_valid[i]);
    end
  end

  // Only the leading run of handshakes counts; bits past the first gap are ignored.
  always_comb begin
    n_out = '0;
    run   = 1'b1;
    for (int j = 0; j < OUT_W; j++) begin
      run   = run & out_valid[j] & out_ready[j];
      n_out = n_out + CW'(run);
    end
  end

  for (genvar i = 0; i < IN_W; i++) begin : g_wr
    assign widx[i] = tail[PW-1:0] + off[i];
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      for (int i = 0; i < IN_W; i++) begin
        if (in_valid[i]) begin
          mem[widx[i]] <= '{inst: in_inst[i*INST_WIDTH +: INST_WIDTH],
                            pc:   in_pc[i*ADDR_WIDTH +: ADDR_WIDTH],
                            pred: in_pred[i]};
        end
      end
    end
  end

  for (genvar j = 0; j < OUT_W; j++) begin : g_rd
    logic [PW-1:0] ridx;
    assign ridx                                = head[PW-1:0] + PW'(j);
    assign out_valid[j]                        = count > CW'(j);
    assign out_inst[j*INST_WIDTH +: INST_WIDTH] = mem[ridx].inst;
    assign out_pc[j*ADDR_WIDTH +: ADDR_WIDTH]   = mem[ridx].pc;
    assign out_pred[j]                         = mem[ridx].pred;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq) tail <= tail + n_in;
      head <= head + n_out;
    end
  end

  a_thermo: assert property (@(posedge clock) disable iff (!reset)
    (out_ready & (out_ready + OUT_W'(1))) == '0);
  a_no_drop: assert property (@(posedge clock) disable iff (!reset)
    (|in_valid && !flush) |-> in_ready);
  a_bound: assert property (@(posedge clock) disable iff (!reset)
    count <= CW'(DEPTH));

endmodule

// File: tb/tb_ysyx_24100029_fetch_queue.sv
// Bench: directed scenarios plus random traffic, checked by a queue-based scoreboard
// that a negedge monitor drains as decode takes entries.
module tb_ysyx_24100029_fetch_queue;
  localparam int D  = 16;
  localparam int IW = 4;
  localparam int OW = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic [3:0]   in_valid = '0, in_pred = '0, out_ready = '0;
  logic [127:0] in_inst = '0, in_pc = '0;
  logic         in_ready;
  logic [3:0]   out_valid, out_pred;
  logic [127:0] out_inst, out_pc;
  logic [4:0]   count;

  ysyx_24100029_fetch_queue #(.DEPTH(D), .IN_W(IW), .OUT_W(OW), .ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_pred(in_pred), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_pred(out_pred),
    .out_ready(out_ready), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t        sb[$];
  int          n_pass = 0, n_tot = 0;
  logic [31:0] lane_pc[4], lane_inst[4];
  logic [3:0]  lane_pred;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic bit model_ready();
    return (D - sb.size()) >= IW;
  endfunction

  function automatic logic [3:0] therm(input int k);
    logic [3:0] t;
    for (int i = 0; i < 4; i++) t[i] = (i < k);
    return t;
  endfunction

  task automatic rand_lanes();
    for (int i = 0; i < 4; i++) begin
      lane_pc[i]   = $urandom;
      lane_inst[i] = $urandom;
      lane_pred[i] = 1'($urandom_range(1, 0));
    end
  endtask

  // Drive one cycle (called at posedge+1), then record what the edge accepted.
  task automatic cycle(input logic [3:0] iv, input logic [3:0] ordy, input logic fl);
    bit rdy;
    rdy       = model_ready();
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_pred   = lane_pred;
    for (int i = 0; i < 4; i++) begin
      in_pc[i*32 +: 32]   = lane_pc[i];
      in_inst[i*32 +: 32] = lane_inst[i];
    end
    @(posedge clock);
    if (fl) sb.delete();
    else if (rdy)
      for (int i = 0; i < 4; i++)
        if (iv[i]) sb.push_back('{inst: lane_inst[i], pc: lane_pc[i], pred: lane_pred[i]});
    #1;
  endtask

  // Monitor: state vs. scoreboard, then pop whatever decode takes this cycle.
  always @(negedge clock) begin
    int   n;
    ent_t e;
    if (reset) begin
      check("count", 64'(count), 64'(sb.size()));
      check("in_ready", 64'(in_ready), 64'(model_ready()));
      check("out_valid", 64'(out_valid), 64'(therm(sb.size() > OW ? OW : sb.size())));
      n = 0;
      while (n < OW && n < sb.size() && out_ready[n]) n++;
      for (int j = 0; j < n; j++) begin
        e = sb.pop_front();
        check("deq_pc", 64'(out_pc[j*32 +: 32]), 64'(e.pc));
        check("deq_inst", 64'(out_inst[j*32 +: 32]), 64'(e.inst));
        check("deq_pred", 64'(out_pred[j]), 64'(e.pred));
      end
    end
  end

  initial begin
    rand_lanes();
    #1 reset = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    // Reset mid-traffic, no clock edge involved.
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    check("pre_rst_count", 64'(count), 64'd9);
    in_valid = '0; out_ready = '0;
    reset = 1'b0;
    #2;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clock); #1;

    // Sparse compaction.
    rand_lanes();
    lane_pc[1] = 32'h8000_0004;
    lane_pc[3] = 32'h8000_000c;
    cycle(4'b1010, 4'b0000, 1'b0);
    check("sparse_out_valid", 64'(out_valid), 64'h3);
    check("sparse_pc0", 64'(out_pc[31:0]), 64'h8000_0004);
    check("sparse_pc1", 64'(out_pc[63:32]), 64'h8000_000c);
    cycle(4'b0000, 4'b1111, 1'b0);

    // Fill and back-pressure thresholds.
    for (int g = 0; g < 4; g++) begin
      rand_lanes();
      cycle(4'b1111, 4'b0000, 1'b0);
      check("fill_in_ready", 64'(in_ready), 64'(g < 3));
    end
    check("full_count", 64'(count), 64'd16);
    cycle(4'b0000, 4'b0111, 1'b0);
    check("c13_count", 64'(count), 64'd13);
    check("c13_in_ready", 64'(in_ready), 64'd0);
    cycle(4'b0000, 4'b0001, 1'b0);
    check("c12_in_ready", 64'(in_ready), 64'd1);
    repeat (3) cycle(4'b0000, 4'b1111, 1'b0);

    // Wrap across index 15 -> 0: bring head=tail=14, then enqueue.
    cycle(4'b0000, 4'b0000, 1'b1);
    repeat (3) begin rand_lanes(); cycle(4'b1111, 4'b0000, 1'b0); end
    rand_lanes();
    cycle(4'b0011, 4'b0000, 1'b0);
    repeat (3) cycle(4'b0000, 4'b1111, 1'b0);
    cycle(4'b0000, 4'b0011, 1'b0);
    check("wrap_empty", 64'(count), 64'd0);
    for (int i = 0; i < 4; i++) lane_pc[i] = 32'h100 + 32'(4 * i);
    cycle(4'b1111, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) lane_pc[i] = 32'h200 + 32'(4 * i);
    cycle(4'b1111, 4'b0011, 1'b0);
    check("wrap_count", 64'(count), 64'd6);
    check("wrap_pc0", 64'(out_pc[31:0]), 64'h108);
    check("wrap_pc2", 64'(out_pc[95:64]), 64'h200);
    repeat (2) cycle(4'b0000, 4'b1111, 1'b0);

    // Flush beats a simultaneous enqueue and dequeue.
    rand_lanes();
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b0111, 4'b0000, 1'b0);
    check("pre_flush_count", 64'(count), 64'd7);
    cycle(4'b1111, 4'b1111, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    lane_pc[2] = 32'hdead_0000;
    cycle(4'b0100, 4'b0000, 1'b0);
    check("post_flush_valid", 64'(out_valid), 64'h1);
    check("post_flush_pc0", 64'(out_pc[31:0]), 64'hdead_0000);
    cycle(4'b0000, 4'b0001, 1'b0);

    // Random stress.
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] iv;
      rand_lanes();
      iv = model_ready() ? 4'($urandom) : 4'b0000;
      cycle(iv, therm($urandom_range(4, 0)), ($urandom_range(99, 0) == 0));
    end
    repeat (6) cycle(4'b0000, 4'b1111, 1'b0);
    check("final_count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
